dcache_controller: RTL and testbench
====================================

// Module: dcache_controller
// PURPOSE
//  Direct-mapped, write-back, write-allocate L1 data cache between the MEM stage and data memory.
//  Drives cpu_stall_o, which feeds stall_i of all four pipeline register stages so the pipeline freezes during a miss.
//  Services misses with an optional dirty-line writeback, then a line refill over a request/ack memory port.
// PARAMETERS
//  NUM_LINES   16   cache lines; must be a power of 2; index = addr[8:5] at default
//  LINE_W      256  line width in bits (32 B, 8 words); offset = addr[4:0], word select = addr[4:2]
//  ADDR_W      32   byte address width; tag = addr[ADDR_W-1:9] (23 bits at default)
// PORTS
//  clk_i          in   1       clock
//  rst_i          in   1       reset, asynchronous, active-high
//  cpu_MemRead_i  in   1       load request from EX/MEM
//  cpu_MemWrite_i in   1       store request from EX/MEM
//  cpu_addr_i     in   ADDR_W  byte address (ALUResult); word-aligned
//  cpu_data_i     in   32      store data (RS2data)
//  cpu_data_o     out  32      load data to MEM/WB MemData_i; valid when request && !cpu_stall_o
//  cpu_stall_o    out  1       freeze pipeline
//  mem_enable_o   out  1       memory request strobe, one cycle
//  mem_write_o    out  1       1 = writeback, 0 = refill; qualified by mem_enable_o
//  mem_addr_o     out  ADDR_W  line-aligned address (low 5 bits 0)
//  mem_data_o     out  LINE_W  victim line for writeback
//  mem_data_i     in   LINE_W  refill line; valid with mem_ack_i
//  mem_ack_i      in   1       one-cycle completion pulse; arrives >=1 cycle after mem_enable_o
// BEHAVIOUR
//  Reset: all valid/dirty bits are 0 and state is IDLE.
//    All outputs are 0: cpu_stall_o, cpu_data_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o.
//    Tag and data arrays are not cleared.
//  req = cpu_MemRead_i | cpu_MemWrite_i. Both high at once is illegal; MemWrite takes priority.
//  hit = valid[idx] && tag[idx] == addr tag.
//  cpu_stall_o = req && !(state==IDLE && hit). Combinational, so it asserts in the same cycle as a miss.
//  Read hit: cpu_data_o = the selected word, combinational, 0 extra latency. cpu_data_o is 0 when there is no request.
//  Write hit (IDLE): at the clock edge, the addressed word is replaced and dirty[idx] is set.
//  FSM states: IDLE, WB_REQ, WB_WAIT, RD_REQ, RD_WAIT.
//   IDLE -> WB_REQ   on req && !hit && valid[idx] && dirty[idx]
//   IDLE -> RD_REQ   on req && !hit && !(valid[idx] && dirty[idx])
//   WB_REQ:  mem_enable_o=1, mem_write_o=1, mem_addr_o={old tag,idx,5'b0}, mem_data_o=victim line -> WB_WAIT
//   WB_WAIT: wait for mem_ack_i -> RD_REQ
//   RD_REQ:  mem_enable_o=1, mem_write_o=0, mem_addr_o={new tag,idx,5'b0} -> RD_WAIT
//   RD_WAIT: on mem_ack_i, write mem_data_i, new tag, valid=1, dirty=0 -> IDLE
//  After the refill, the held request hits in IDLE. The stall drops that cycle; a store then merges and sets dirty.
//  Miss penalty = 1 + memory latency per transfer, plus 1 replay cycle.
//  mem_ack_i outside WB_WAIT/RD_WAIT is ignored.
//  mem_enable_o is 0 in all states except the two *_REQ states; mem_addr_o and mem_data_o hold their last value.
//  The CPU holds addr, data and request stable while stalled.
//    If req drops mid-miss, the transfer still completes and the line is installed; no CPU write occurs.
//  Reset mid-miss aborts to IDLE and clears all valid bits. The memory must drop any pending ack.
//  Address wrap: index/tag are pure bit slices; there is no boundary special case.
// STRUCTURE
//  dcache_pkg: state enum, OFFSET_W=5, INDEX_W, TAG_W, WORD_SEL_W=3, line/word typedefs.
//  Sub-module dcache_sram: tag/valid/dirty/data arrays, async read and sync write, async clear of valid/dirty.
//  The controller holds the FSM, hit logic, word merge/select and memory port registers.
// TESTING
//  1. Cold read 0x0000_0040: mem_enable_o=1, mem_write_o=0, mem_addr_o=0x40, stall high.
//     Ack with word0=0xDEADBEEF -> next cycle stall=0, cpu_data_o=0xDEADBEEF.
//  2. Read 0x44 right after test 1 -> hit: no stall, cpu_data_o=word1, mem_enable_o stays 0.
//  3. Write hit 0x48 data 0x1234_5678 -> no stall, dirty[2]=1. A read of 0x48 returns 0x12345678.
//  4. Read 0x0000_0240 (same idx 2, new tag) -> WB_REQ: mem_addr_o=0x40, mem_write_o=1,
//     mem_data_o word2=0x12345678. After ack -> RD_REQ with mem_addr_o=0x240.
//  5. Assert rst_i in RD_WAIT -> all outputs 0 asynchronously. A later read of 0x40 misses: valid was cleared.
//  6. Memory latency 10 cycles: stall stays 1 for exactly 1+10+1 cycles on a clean miss.
//     Pipeline registers hold their values throughout.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and default geometry for the direct-mapped L1 data cache.
package dcache_pkg;

  localparam int OFFSET_W   = 5;
  localparam int WORD_SEL_W = 3;
  localparam int WORD_W     = 32;

  localparam int DEF_NUM_LINES = 16;
  localparam int DEF_LINE_W    = 256;
  localparam int DEF_ADDR_W    = 32;
  localparam int INDEX_W       = $clog2(DEF_NUM_LINES);
  localparam int TAG_W         = DEF_ADDR_W - INDEX_W - OFFSET_W;

  typedef logic [WORD_W-1:0]     word_t;
  typedef logic [DEF_LINE_W-1:0] line_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WB_REQ  = 3'd1,
    WB_WAIT = 3'd2,
    RD_REQ  = 3'd3,
    RD_WAIT = 3'd4
  } state_t;

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage for the data cache: asynchronous read, synchronous write.
// Valid and dirty bits clear asynchronously on reset; tags and data are left as they are.
module dcache_sram #(
  parameter int NUM_LINES = 16,
  parameter int INDEX_W   = 4,
  parameter int TAG_W     = 23,
  parameter int LINE_W    = 256
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [INDEX_W-1:0] rd_idx,
  output logic [TAG_W-1:0]   rd_tag,
  output logic               rd_valid,
  output logic               rd_dirty,
  output logic [LINE_W-1:0]  rd_line,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [LINE_W-1:0]  wr_line,
  input  logic               wr_dirty
);

  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [LINE_W-1:0]    data_mem [NUM_LINES];
  logic [NUM_LINES-1:0] valid;
  logic [NUM_LINES-1:0] dirty;

  assign rd_tag   = tag_mem[rd_idx];
  assign rd_line  = data_mem[rd_idx];
  assign rd_valid = valid[rd_idx];
  assign rd_dirty = dirty[rd_idx];

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_line;
    end
  end

  // Every write installs or updates a line, so it always leaves the line valid.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid <= '0;
      dirty <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
      dirty[wr_idx] <= wr_dirty;
    end
  end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller.
// Stalls the pipeline while a miss runs an optional victim writeback followed by a line refill.
module dcache_controller #(
  parameter int NUM_LINES = 16,
  parameter int LINE_W    = 256,
  parameter int ADDR_W    = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_MemRead_i,
  input  logic              cpu_MemWrite_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [31:0]       cpu_data_i,
  output logic [31:0]       cpu_data_o,
  output logic              cpu_stall_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
);

  import dcache_pkg::*;

  localparam int LINE_IDX_W = $clog2(NUM_LINES);
  localparam int LINE_TAG_W = ADDR_W - LINE_IDX_W - OFFSET_W;
  localparam int LANE_W     = $clog2(LINE_W);

  state_t                  state;
  logic [LINE_IDX_W-1:0]   idx;
  logic [LINE_TAG_W-1:0]   tag;
  logic [WORD_SEL_W-1:0]   word_sel;
  logic [LANE_W-1:0]       lane;
  logic [LINE_IDX_W-1:0]   miss_idx;
  logic [LINE_TAG_W-1:0]   miss_tag;

  logic                    req;
  logic                    rd_req;
  logic                    hit;
  logic                    idle_hit;

  logic [LINE_TAG_W-1:0]   line_tag;
  logic                    line_valid;
  logic                    line_dirty;
  logic [LINE_W-1:0]       line_data;
  logic [LINE_W-1:0]       merged;

  logic                    wr_en;
  logic [LINE_IDX_W-1:0]   wr_idx;
  logic [LINE_TAG_W-1:0]   wr_tag;
  logic [LINE_W-1:0]       wr_line;
  logic                    wr_dirty;

  logic                    addr_lsb_unused;

  assign idx      = cpu_addr_i[OFFSET_W +: LINE_IDX_W];
  assign tag      = cpu_addr_i[ADDR_W-1 -: LINE_TAG_W];
  assign word_sel = cpu_addr_i[2 +: WORD_SEL_W];
  assign lane     = LANE_W'({word_sel, 5'b00000});
  assign addr_lsb_unused = ^cpu_addr_i[1:0];

  dcache_sram #(
    .NUM_LINES (NUM_LINES),
    .INDEX_W   (LINE_IDX_W),
    .TAG_W     (LINE_TAG_W),
    .LINE_W    (LINE_W)
  ) u_sram (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .rd_idx   (idx),
    .rd_tag   (line_tag),
    .rd_valid (line_valid),
    .rd_dirty (line_dirty),
    .rd_line  (line_data),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .wr_tag   (wr_tag),
    .wr_line  (wr_line),
    .wr_dirty (wr_dirty)
  );

  // A store wins over a load when both strobes are raised together.
  assign req      = cpu_MemRead_i | cpu_MemWrite_i;
  assign rd_req   = cpu_MemRead_i & ~cpu_MemWrite_i;
  assign hit      = line_valid && (line_tag == tag);
  assign idle_hit = (state == IDLE) && hit;

  assign cpu_stall_o = !rst_i && req && !idle_hit;
  assign cpu_data_o  = (!rst_i && rd_req && idle_hit) ? line_data[lane +: WORD_W] : '0;

  always_comb begin
    merged = line_data;
    merged[lane +: WORD_W] = cpu_data_i;
  end

  // The refill uses the tag/index captured at miss time, so a dropped request still installs its line.
  always_comb begin
    wr_en    = 1'b0;
    wr_idx   = idx;
    wr_tag   = tag;
    wr_line  = merged;
    wr_dirty = 1'b1;
    if (state == RD_WAIT && mem_ack_i) begin
      wr_en    = 1'b1;
      wr_idx   = miss_idx;
      wr_tag   = miss_tag;
      wr_line  = mem_data_i;
      wr_dirty = 1'b0;
    end else if (state == IDLE && cpu_MemWrite_i && hit) begin
      wr_en = 1'b1;
    end
  end

  // Memory port outputs are registered on entry to each *_REQ state so they are valid for exactly that cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
      miss_idx     <= '0;
      miss_tag     <= '0;
    end else begin
      mem_enable_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req && !hit) begin
            miss_idx     <= idx;
            miss_tag     <= tag;
            mem_enable_o <= 1'b1;
            if (line_valid && line_dirty) begin
              state       <= WB_REQ;
              mem_write_o <= 1'b1;
              mem_addr_o  <= {line_tag, idx, {OFFSET_W{1'b0}}};
              mem_data_o  <= line_data;
            end else begin
              state       <= RD_REQ;
              mem_write_o <= 1'b0;
              mem_addr_o  <= {tag, idx, {OFFSET_W{1'b0}}};
            end
          end
        end
        WB_REQ: state <= WB_WAIT;
        WB_WAIT: begin
          if (mem_ack_i) begin
            state        <= RD_REQ;
            mem_enable_o <= 1'b1;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= {miss_tag, miss_idx, {OFFSET_W{1'b0}}};
          end
        end
        RD_REQ: state <= RD_WAIT;
        RD_WAIT: begin
          if (mem_ack_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Scoreboard bench for dcache_controller: a flat-memory reference model predicts load data and stall lengths.
module tb_dcache_controller;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         cpu_MemRead_i;
  logic         cpu_MemWrite_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_data_i;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;

  dcache_controller dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .cpu_MemRead_i  (cpu_MemRead_i),
    .cpu_MemWrite_i (cpu_MemWrite_i),
    .cpu_addr_i     (cpu_addr_i),
    .cpu_data_i     (cpu_data_i),
    .cpu_data_o     (cpu_data_o),
    .cpu_stall_o    (cpu_stall_o),
    .mem_enable_o   (mem_enable_o),
    .mem_write_o    (mem_write_o),
    .mem_addr_o     (mem_addr_o),
    .mem_data_o     (mem_data_o),
    .mem_data_i     (mem_data_i),
    .mem_ack_i      (mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          is_read;
    logic [31:0] addr;
    logic [31:0] data;
    int          stalls;
  } sb_entry_t;

  sb_entry_t    sb_q[$];
  int           n_compared = 0;
  int           n_mismatched = 0;
  int           mem_lat = 1;

  // CPU-visible memory (word granularity) and the backing store behind the cache (line granularity).
  logic [31:0]  ref_mem  [logic [29:0]];
  logic [255:0] back_mem [logic [26:0]];
  bit           m_valid [16];
  bit           m_dirty [16];
  logic [22:0]  m_tag   [16];

  function automatic logic [31:0] initWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [255:0] initLine(input logic [31:0] la);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = initWord(la + 32'(w * 4));
    return l;
  endfunction

  function automatic logic [31:0] refWord(input logic [31:0] a);
    if (ref_mem.exists(a[31:2])) return ref_mem[a[31:2]];
    return initWord({a[31:2], 2'b00});
  endfunction

  function automatic logic [255:0] refLine(input logic [31:0] a);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = refWord({a[31:5], 3'(w), 2'b00});
    return l;
  endfunction

  function automatic logic [255:0] backLine(input logic [31:0] a);
    if (back_mem.exists(a[31:5])) return back_mem[a[31:5]];
    return initLine({a[31:5], 5'b00000});
  endfunction

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic finishRun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  endtask

  // Predicts the effect of one access: residency, stall length and the CPU-visible data.
  task automatic modelAccess(input bit wr, input logic [31:0] a, input logic [31:0] d,
                             output sb_entry_t e);
    int          i;
    bit          h;
    logic [22:0] tg;
    i  = int'(a[8:5]);
    tg = a[31:9];
    h  = m_valid[i] && (m_tag[i] == tg);
    if (h)                          e.stalls = 0;
    else if (m_valid[i] && m_dirty[i]) e.stalls = 2 * mem_lat + 3;
    else                            e.stalls = mem_lat + 2;
    if (!h) begin
      m_valid[i] = 1'b1;
      m_tag[i]   = tg;
      m_dirty[i] = 1'b0;
    end
    if (wr) begin
      ref_mem[a[31:2]] = d;
      m_dirty[i] = 1'b1;
    end
    e.is_read = !wr;
    e.addr    = a;
    e.data    = wr ? 32'h0 : refWord(a);
  endtask

  // A reset loses dirty data, so the CPU view of those lines falls back to the backing store.
  task automatic resetModel();
    logic [31:0]  la;
    logic [255:0] bl;
    for (int i = 0; i < 16; i++) begin
      if (m_valid[i] && m_dirty[i]) begin
        la = {m_tag[i], 4'(i), 5'b00000};
        bl = backLine(la);
        for (int w = 0; w < 8; w++) ref_mem[{la[31:5], 3'(w)}] = bl[w*32 +: 32];
      end
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endtask

  task automatic applyStimulus(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d);
    sb_entry_t e;
    int        n;
    cpu_MemWrite_i = wr;
    cpu_MemRead_i  = rd;
    cpu_addr_i     = a;
    cpu_data_i     = d;
    modelAccess(wr, a, d, e);
    sb_q.push_back(e);
    n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (cpu_stall_o && n < 300);
    if (cpu_stall_o) begin
      checkOutput("accept_timeout", 256'(1), 256'(0));
      finishRun();
    end
    @(posedge clk_i);
    #1;
    cpu_MemRead_i  = 1'b0;
    cpu_MemWrite_i = 1'b0;
  endtask

  task automatic waitMemReq(input bit want_write, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk_i);
      if (mem_enable_o && (mem_write_o == want_write)) ok = 1'b1;
    end
    if (!ok) checkOutput("mem_req_timeout", 256'(0), 256'(1));
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_stall",    256'(cpu_stall_o),  256'(0));
    checkOutput("rst_cpu_data", 256'(cpu_data_o),   256'(0));
    checkOutput("rst_mem_en",   256'(mem_enable_o), 256'(0));
    checkOutput("rst_mem_wr",   256'(mem_write_o),  256'(0));
    checkOutput("rst_mem_addr", 256'(mem_addr_o),   256'(0));
    checkOutput("rst_mem_data", mem_data_o,         256'(0));
  endtask

  task automatic serveMem();
    logic [31:0]  a;
    logic [255:0] d;
    bit           wr;
    bit           aborted;
    a       = mem_addr_o;
    d       = mem_data_o;
    wr      = mem_write_o;
    aborted = 1'b0;
    checkOutput("mem_addr_align", 256'(a[4:0]), 256'(0));
    if (wr) begin
      checkOutput("wb_line", d, refLine(a));
      back_mem[a[31:5]] = d;
    end
    for (int i = 0; i < mem_lat && !aborted; i++) begin
      @(negedge clk_i);
      if (rst_i) aborted = 1'b1;
    end
    if (!aborted) begin
      mem_data_i = wr ? 256'h0 : backLine(a);
      mem_ack_i  = 1'b1;
      @(negedge clk_i);
      mem_ack_i  = 1'b0;
    end
  endtask

  initial begin : memory_model
    forever begin
      @(negedge clk_i);
      while (mem_enable_o && !rst_i) serveMem();
    end
  end

  initial begin : monitor
    sb_entry_t e;
    int        stall_cnt;
    stall_cnt = 0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        stall_cnt = 0;
      end else if (cpu_MemRead_i || cpu_MemWrite_i) begin
        if (cpu_stall_o) begin
          stall_cnt++;
        end else begin
          if (sb_q.size() == 0) begin
            checkOutput("sb_underflow", 256'(1), 256'(0));
          end else begin
            e = sb_q.pop_front();
            if (e.is_read) checkOutput("load_data", 256'(cpu_data_o), 256'(e.data));
            checkOutput("stall_cycles", 256'(stall_cnt), 256'(e.stalls));
          end
          stall_cnt = 0;
        end
      end else begin
        checkOutput("idle_outputs", 256'({cpu_stall_o, cpu_data_o}), 256'(0));
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic [22:0]  tags [4];
    logic [255:0] l0;
    logic [255:0] wl;
    logic [31:0]  a;
    sb_entry_t    e;
    bit           ok;
    int           k;

    rst_i = 1'b1;
    cpu_MemRead_i  = 1'b0;
    cpu_MemWrite_i = 1'b0;
    cpu_addr_i = '0;
    cpu_data_i = '0;
    mem_data_i = '0;
    mem_ack_i  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
      m_tag[i]   = '0;
    end
    l0 = initLine(32'h40);
    l0[31:0] = 32'hDEAD_BEEF;
    back_mem[27'h2] = l0;
    ref_mem[30'h10] = 32'hDEAD_BEEF;

    repeat (3) @(posedge clk_i);
    #1;
    checkResetOutputs();
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    $display("[TB] cold miss, hit, write hit");
    mem_lat = 1;
    applyStimulus(1'b0, 1'b1, 32'h0000_0040, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h0000_0044, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0000_0048, 32'h1234_5678);
    applyStimulus(1'b0, 1'b1, 32'h0000_0048, 32'h0);

    $display("[TB] dirty eviction interrupted by reset");
    mem_lat = 3;
    cpu_MemRead_i = 1'b1;
    cpu_addr_i    = 32'h0000_0240;
    modelAccess(1'b0, 32'h0000_0240, 32'h0, e);
    waitMemReq(1'b1, ok);
    if (ok) begin
      wl = mem_data_o;
      checkOutput("wb_addr",  256'(mem_addr_o), 256'(32'h40));
      checkOutput("wb_word2", 256'(wl[95:64]),  256'(32'h1234_5678));
    end
    waitMemReq(1'b0, ok);
    if (ok) checkOutput("refill_addr", 256'(mem_addr_o), 256'(32'h240));
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    #1;
    checkResetOutputs();
    resetModel();
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    cpu_MemRead_i = 1'b0;
    @(posedge clk_i);
    #1;

    $display("[TB] clean miss with long memory latency");
    mem_lat = 10;
    applyStimulus(1'b0, 1'b1, 32'h0000_0040, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h0000_0048, 32'h0);

    $display("[TB] random traffic");
    tags[0] = 23'h0;
    tags[1] = 23'h1;
    tags[2] = 23'h2;
    tags[3] = 23'h7F_FFFF;
    for (int i = 0; i < 150; i++) begin
      a = {tags[$urandom_range(0, 3)], 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 2'b00};
      mem_lat = $urandom_range(1, 4);
      k = $urandom_range(0, 9);
      if (k < 5)      applyStimulus(1'b0, 1'b1, a, $urandom);
      else if (k < 9) applyStimulus(1'b1, 1'b0, a, $urandom);
      else            applyStimulus(1'b1, 1'b1, a, $urandom);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk_i);
        #1;
      end
    end

    repeat (5) @(posedge clk_i);
    checkOutput("sb_drain", 256'(sb_q.size()), 256'(0));
    finishRun();
  end

endmodule
